// File: rtl/input_frame_rx_if.sv
// ---------------------------------------------------------------------------
// input_frame_rx_if
//   Bundles the serial input line and the decoded-frame outputs of the UART
//   frame assembler so the receiver and its consumer connect through a
//   single port.
//
//   Signals:
//     uart_rx     serial line, idle high, 8N1, LSB first
//     sign_out    sign bit of the last valid frame
//     data_out    42-bit magnitude of the last valid frame
//     frame_valid one-cycle strobe when sign_out/data_out are updated
//     frame_err   one-cycle strobe on framing, format or timeout error
//     busy        frame partially received or byte in progress
//
//   Modports:
//     master  the receiver: samples uart_rx, produces the frame outputs
//     slave   the line driver / frame consumer
// ---------------------------------------------------------------------------
interface input_frame_rx_if;
  logic        uart_rx;
  logic        sign_out;
  logic [41:0] data_out;
  logic        frame_valid;
  logic        frame_err;
  logic        busy;

  modport master (
    input  uart_rx,
    output sign_out,
    output data_out,
    output frame_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output uart_rx,
    input  sign_out,
    input  data_out,
    input  frame_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/input_frame_rx.sv
// ---------------------------------------------------------------------------
// input_frame_rx
//   UART receive-side frame assembler for the CORDIC host link. Deserialises
//   8N1 bytes from the line, packs six of them (MSB byte first) into a 48-bit
//   frame and checks its format: bit 47 sign, bits 46:42 zero, bits 41:0
//   magnitude. A good frame updates sign_out/data_out with a frame_valid
//   strobe; a bad stop bit or a bad format gives a frame_err strobe.
//
//   Parameters:
//     CLK_FREQ       system clock in Hz
//     BAUD           line rate; bit period DIV = CLK_FREQ/BAUD (truncated)
//     TIMEOUT_BYTES  inter-byte gap limit in byte times (timeout build only)
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    input_frame_rx_if.master (uart_rx in; frame outputs out)
//
//   Build option:
//     INPUT_RX_TIMEOUT_EN  when defined, a partial frame is abandoned (byte
//                          count cleared, frame_err pulsed) after the line
//                          stays idle for TIMEOUT_BYTES*10*DIV cycles.
// ---------------------------------------------------------------------------
module input_frame_rx #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD          = 115200,
  parameter int TIMEOUT_BYTES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input_frame_rx_if.master   bus
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);

  // Last count of a full bit period.
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DIV - 1);
  // The start-bit check is taken two cycles early to absorb the edge
  // detector delay, which puts every later sample near mid-bit.
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(DIV / 2 - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Line synchroniser and edge detector (idle-high reset values).
  logic rx_meta_reg;
  logic rx_sync_reg;
  logic rx_prev_reg;
  logic start_edge;

  state_t             state_reg;
  logic [CNT_W-1:0]   baud_cnt_reg;
  logic [2:0]         bit_idx_reg;
  logic [7:0]         shift_reg;
  logic [2:0]         byte_cnt_reg;
  logic [47:0]        frame_reg;
  logic               sign_out_reg;
  logic [41:0]        data_out_reg;
  logic               frame_valid_reg;
  logic               frame_err_reg;

  logic [47:0]        frame_next;
  logic               frame_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= bus.uart_rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  assign start_edge = rx_prev_reg & ~rx_sync_reg;

  // Frame image with the byte currently in the shift register dropped into
  // its lane: byte k of the frame occupies lane 5-k (bits 47-8k : 40-8k).
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_lane
      assign frame_next[8*gi +: 8] = (byte_cnt_reg == 3'(5 - gi)) ?
                                     shift_reg : frame_reg[8*gi +: 8];
    end
  endgenerate

  assign frame_ok = (frame_next[46:42] == 5'd0);

`ifdef INPUT_RX_TIMEOUT_EN
  localparam int GAP_CYCLES = TIMEOUT_BYTES * 10 * DIV;
  localparam int GAP_W      = $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  logic [GAP_W-1:0] gap_cnt_reg;
`else
  // Without the gap timer the limit has no effect; this empty block only
  // keeps the parameter referenced.
  if (TIMEOUT_BYTES < 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      baud_cnt_reg    <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      byte_cnt_reg    <= '0;
      frame_reg       <= '0;
      sign_out_reg    <= 1'b0;
      data_out_reg    <= '0;
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
`ifdef INPUT_RX_TIMEOUT_EN
      gap_cnt_reg     <= '0;
`endif
    end else begin
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;

      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          if (start_edge) begin
            state_reg <= START;
          end
        end

        START: begin
          if (baud_cnt_reg == START_LAST) begin
            baud_cnt_reg <= '0;
            if (rx_sync_reg) begin
              // Glitch, not a start bit; partial frame is kept.
              state_reg <= IDLE;
            end else begin
              state_reg   <= DATA;
              bit_idx_reg <= '0;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {rx_sync_reg, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg <= '0;
            state_reg    <= IDLE;
            if (rx_sync_reg) begin
              frame_reg <= frame_next;
              if (byte_cnt_reg == 3'd5) begin
                byte_cnt_reg <= '0;
                if (frame_ok) begin
                  sign_out_reg    <= frame_next[47];
                  data_out_reg    <= frame_next[41:0];
                  frame_valid_reg <= 1'b1;
                end else begin
                  frame_err_reg <= 1'b1;
                end
              end else begin
                byte_cnt_reg <= byte_cnt_reg + 1'b1;
              end
            end else begin
              // Bad stop bit: drop the byte and resynchronise on a new frame.
              frame_err_reg <= 1'b1;
              byte_cnt_reg  <= '0;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase

`ifdef INPUT_RX_TIMEOUT_EN
      // Gap timer only runs while idling inside a partial frame; any start
      // edge or leaving IDLE restarts it.
      if (state_reg == IDLE && byte_cnt_reg != 3'd0 && !start_edge) begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_reg   <= '0;
          byte_cnt_reg  <= '0;
          frame_err_reg <= 1'b1;
        end else begin
          gap_cnt_reg <= gap_cnt_reg + 1'b1;
        end
      end else begin
        gap_cnt_reg <= '0;
      end
`endif
    end
  end

  assign bus.sign_out    = sign_out_reg;
  assign bus.data_out    = data_out_reg;
  assign bus.frame_valid = frame_valid_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.busy        = (state_reg != IDLE) || (byte_cnt_reg != 3'd0);

endmodule

// File: tb/tb_input_frame_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_input_frame_rx
//   Scoreboard bench for input_frame_rx at CLK_FREQ=1 MHz, BAUD=100 kHz
//   (DIV=10). Expected pulses are queued as stimulus is driven and checked
//   by a monitor when the DUT strobes frame_valid or frame_err.
// ---------------------------------------------------------------------------
module tb_input_frame_rx;
  localparam int CLK_FREQ      = 1_000_000;
  localparam int BAUD          = 100_000;
  localparam int DIV           = CLK_FREQ / BAUD;
  localparam int TIMEOUT_BYTES = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  input_frame_rx_if rx_if ();

  input_frame_rx #(
    .CLK_FREQ      (CLK_FREQ),
    .BAUD          (BAUD),
    .TIMEOUT_BYTES (TIMEOUT_BYTES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rx_if)
  );

  typedef struct packed {
    logic        is_err;
    logic        sign;
    logic [41:0] data;
  } exp_t;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          pulse_cnt   = 0;
  int          last_start_cyc = 0;
  int          last_valid_cyc = 0;
  int          last_err_cyc   = 0;
  logic        exp_sign = 1'b0;
  logic [41:0] exp_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rx_if.frame_valid || rx_if.frame_err) begin
      pulse_cnt++;
      vectors++;
      if (rx_if.frame_valid && rx_if.frame_err) begin
        miscompares++;
        $display("FAIL pulse_overlap valid=1 err=1 required at most one");
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse valid=%0b err=%0b required none",
                 rx_if.frame_valid, rx_if.frame_err);
      end else begin
        e = sb.pop_front();
        if (e.is_err) begin
          last_err_cyc = cyc;
          if (!rx_if.frame_err) begin
            miscompares++;
            $display("FAIL pulse_kind got valid required err");
          end else if (rx_if.sign_out !== exp_sign || rx_if.data_out !== exp_data) begin
            miscompares++;
            $display("FAIL err_hold got %0b/%h required %0b/%h",
                     rx_if.sign_out, rx_if.data_out, exp_sign, exp_data);
          end else begin
            $display("err   cyc=%0d outputs held %0b/%h", cyc, exp_sign, exp_data);
          end
        end else begin
          last_valid_cyc = cyc;
          if (!rx_if.frame_valid) begin
            miscompares++;
            $display("FAIL pulse_kind got err required valid");
          end else if (rx_if.sign_out !== e.sign || rx_if.data_out !== e.data) begin
            miscompares++;
            $display("FAIL frame_data got %0b/%h required %0b/%h",
                     rx_if.sign_out, rx_if.data_out, e.sign, e.data);
          end else begin
            $display("valid cyc=%0d sign=%0b data=%h", cyc, e.sign, e.data);
          end
          exp_sign = e.sign;
          exp_data = e.data;
        end
      end
    end
  end

  // Drive one 8N1 character; called and returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_if.uart_rx  = 1'b0;
    last_start_cyc = cyc;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_if.uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx_if.uart_rx = stop;
    repeat (DIV) @(negedge clk);
    rx_if.uart_rx = 1'b1;
  endtask

  // Expected outcome of a complete six-byte frame.
  task automatic push_frame(input logic [47:0] f);
    if (f[46:42] == 5'd0) sb.push_back({1'b0, f[47], f[41:0]});
    else                  sb.push_back({1'b1, 1'b0, 42'd0});
  endtask

  task automatic send_frame(input logic [47:0] f);
    push_frame(f);
    for (int k = 0; k < 6; k++) send_byte(f[47-8*k -: 8], 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    rx_if.uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rx_if.sign_out, rx_if.data_out, rx_if.frame_valid, rx_if.frame_err, rx_if.busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %0b/%h/%0b/%0b/%0b required all 0",
               rx_if.sign_out, rx_if.data_out, rx_if.frame_valid, rx_if.frame_err, rx_if.busy);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (rx_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got %0b required 0", rx_if.busy);
    end
  endtask

  task automatic test_valid_frame();
    send_frame(48'h80_00_00_00_12_34);
    wait_drain();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL valid_missing pending=%0d required 0", sb.size());
      sb.delete();
    end
    vectors++;
    if (last_valid_cyc - last_start_cyc != 97) begin
      miscompares++;
      $display("FAIL valid_latency got %0d required 97", last_valid_cyc - last_start_cyc);
    end
    vectors++;
    if (rx_if.sign_out !== 1'b1 || rx_if.data_out !== 42'h00000001234 || rx_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL valid_outputs got %0b/%h busy=%0b required 1/00000001234 busy=0",
               rx_if.sign_out, rx_if.data_out, rx_if.busy);
    end
  endtask

  task automatic test_format_error();
    send_frame(48'h84_00_00_00_00_01);
    wait_drain();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL format_missing pending=%0d required 0", sb.size());
      sb.delete();
    end
    vectors++;
    if (rx_if.sign_out !== 1'b1 || rx_if.data_out !== 42'h00000001234) begin
      miscompares++;
      $display("FAIL format_hold got %0b/%h required 1/00000001234",
               rx_if.sign_out, rx_if.data_out);
    end
  endtask

  task automatic test_framing_error();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    sb.push_back({1'b1, 1'b0, 42'd0});
    send_byte(8'h44, 1'b0);
    repeat (20) @(negedge clk);
    wait_drain();
    vectors++;
    if (sb.size() != 0 || rx_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL framing_err pending=%0d busy=%0b required 0/0", sb.size(), rx_if.busy);
      sb.delete();
    end
    send_frame(48'h00_00_00_00_00_07);
    wait_drain();
    vectors++;
    if (sb.size() != 0 || rx_if.sign_out !== 1'b0 || rx_if.data_out !== 42'd7) begin
      miscompares++;
      $display("FAIL framing_recover pending=%0d got %0b/%h required 0/7",
               sb.size(), rx_if.sign_out, rx_if.data_out);
      sb.delete();
    end
  endtask

  task automatic test_false_start();
    int pulses_before;
    pulses_before = pulse_cnt;
    rx_if.uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    rx_if.uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    vectors++;
    if (pulse_cnt != pulses_before || rx_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL false_start pulses=%0d busy=%0b required 0/0",
               pulse_cnt - pulses_before, rx_if.busy);
    end
    // Largest legal magnitude with sign set.
    send_frame(48'h83_FF_FF_FF_FF_FF);
    wait_drain();
    vectors++;
    if (sb.size() != 0 || rx_if.sign_out !== 1'b1 || rx_if.data_out !== 42'h3FFFFFFFFFF) begin
      miscompares++;
      $display("FAIL false_start_recover pending=%0d got %0b/%h required 1/3ffffffffff",
               sb.size(), rx_if.sign_out, rx_if.data_out);
      sb.delete();
    end
  endtask

  task automatic test_timeout();
    int pulses_before;
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
`ifdef INPUT_RX_TIMEOUT_EN
    sb.push_back({1'b1, 1'b0, 42'd0});
    repeat (250) @(negedge clk);
    wait_drain();
    vectors++;
    if (sb.size() != 0 || rx_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_err pending=%0d busy=%0b required 0/0", sb.size(), rx_if.busy);
      sb.delete();
    end
    vectors++;
    if (last_err_cyc - last_start_cyc < 296 || last_err_cyc - last_start_cyc > 298) begin
      miscompares++;
      $display("FAIL timeout_time got %0d required 297 (+-1)", last_err_cyc - last_start_cyc);
    end
    send_frame(48'h00_01_23_45_67_89);
`else
    pulses_before = pulse_cnt;
    repeat (250) @(negedge clk);
    vectors++;
    if (pulse_cnt != pulses_before || rx_if.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_wait pulses=%0d busy=%0b required 0/1",
               pulse_cnt - pulses_before, rx_if.busy);
    end
    push_frame(48'h00_01_23_45_67_89);
    send_byte(8'h23, 1'b1);
    send_byte(8'h45, 1'b1);
    send_byte(8'h67, 1'b1);
    send_byte(8'h89, 1'b1);
`endif
    wait_drain();
    vectors++;
    if (sb.size() != 0 || rx_if.sign_out !== 1'b0 || rx_if.data_out !== 42'h00123456789) begin
      miscompares++;
      $display("FAIL timeout_frame pending=%0d got %0b/%h required 0/00123456789",
               sb.size(), rx_if.sign_out, rx_if.data_out);
      sb.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h80, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    rx_if.uart_rx = 1'b0;
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rx_if.sign_out, rx_if.data_out, rx_if.frame_valid, rx_if.frame_err, rx_if.busy} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs got %0b/%h/%0b/%0b/%0b required all 0",
               rx_if.sign_out, rx_if.data_out, rx_if.frame_valid, rx_if.frame_err, rx_if.busy);
    end
    exp_sign      = 1'b0;
    exp_data      = '0;
    rx_if.uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(48'h80_00_00_00_00_01);
    wait_drain();
    vectors++;
    if (sb.size() != 0 || rx_if.sign_out !== 1'b1 || rx_if.data_out !== 42'd1) begin
      miscompares++;
      $display("FAIL midreset_recover pending=%0d got %0b/%h required 1/1",
               sb.size(), rx_if.sign_out, rx_if.data_out);
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] fa;
    logic [47:0] fb;
    fa = 48'h00_0A_BC_DE_F0_12;
    fb = 48'h81_23_45_67_89_AB;
    push_frame(fa);
    push_frame(fb);
    for (int k = 0; k < 6; k++) send_byte(fa[47-8*k -: 8], 1'b1);
    for (int k = 0; k < 6; k++) send_byte(fb[47-8*k -: 8], 1'b1);
    wait_drain();
    vectors++;
    if (sb.size() != 0 || rx_if.sign_out !== 1'b1 || rx_if.data_out !== 42'h123456789AB) begin
      miscompares++;
      $display("FAIL back_to_back pending=%0d got %0b/%h required 1/123456789ab",
               sb.size(), rx_if.sign_out, rx_if.data_out);
      sb.delete();
    end
  endtask

  initial begin
    rx_if.uart_rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_valid_frame();
    test_format_error();
    test_framing_error();
    test_false_start();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
